// File: rtl/pixart_init_sequencer.sv
// -----------------------------------------------------------------------------
// pixart_init_sequencer
//
// Boot-time configuration sequencer for the PixArt IR camera. On a go pulse it
// walks a fixed init table and sends each entry to the camera as one
// single-byte I2C write through i2c_master's start/ready handshake. After each
// completed write it waits a settle gap before starting the next one.
//
// Handshake with i2c_master (all decisions use rdy, the synchronised i2c_ready):
//   - i2c_start rises only while rdy=1. It stays high until the master
//     acknowledges by dropping rdy, and then falls.
//   - rdy rising again means the write has finished.
//   - i2c_data and i2c_addr are stable from the table load until the write
//     finishes. The master samples them when it sees i2c_start.
//   - Each handshake phase has a TIMEOUT-cycle budget. If the budget runs out,
//     the sequence aborts into ERROR. There are no retries.
//
// Ports:
//   clk        in   system clock (i2c_master runs from a clock derived from it)
//   reset_n    in   asynchronous active-low reset
//   go         in   1-cycle start pulse, accepted in IDLE, DONE and ERROR
//   i2c_start  out  write request to i2c_master
//   i2c_addr   out  7-bit device address, constant DEV_ADDR
//   i2c_data   out  table byte for the current entry
//   i2c_ready  in   master idle and out of reset (asynchronous to the FSM)
//   busy       out  sequence in progress
//   done       out  whole table written; held until the next go
//   error      out  a handshake timed out; held until the next go
//   step       out  table entry in progress, or the last one attempted
//   state_dbg  out  current FSM state (0=IDLE 1=LOAD 2=ISSUE 3=ACCEPT
//                   4=COMPLETE 5=GAP 6=DONE 7=ERROR)
// -----------------------------------------------------------------------------
module pixart_init_sequencer #(
    parameter logic [6:0]  DEV_ADDR   = 7'h58,
    parameter int          NUM_BYTES  = 12,
    parameter logic [15:0] GAP_CYCLES = 16'd5000,
    parameter logic [15:0] TIMEOUT    = 16'd2000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    output logic       i2c_start,
    output logic [6:0] i2c_addr,
    output logic [7:0] i2c_data,
    input  logic       i2c_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] step,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_ISSUE    = 3'd2,
        S_ACCEPT   = 3'd3,
        S_COMPLETE = 3'd4,
        S_GAP      = 3'd5,
        S_DONE     = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    // This is the last table index sent. Entries after it are never read.
    localparam logic [3:0]  LAST_STEP = 4'(NUM_BYTES - 1);
    // The gap counter starts at 0, so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [15:0] GAP_LAST  = GAP_CYCLES - 16'd1;

    state_t      state;
    logic [15:0] tmr;
    logic [15:0] gap_cnt;
    logic        ready_meta;
    logic        rdy;

    assign i2c_addr  = DEV_ADDR;
    assign state_dbg = state;

    // This is the camera init table, with entry 0 first. Indices 12..15 read as 0.
    function automatic logic [7:0] table_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h30;
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h30;
            4'd3:    b = 8'h08;
            4'd4:    b = 8'h06;
            4'd5:    b = 8'h90;
            4'd6:    b = 8'h08;
            4'd7:    b = 8'hC0;
            4'd8:    b = 8'h1A;
            4'd9:    b = 8'h40;
            4'd10:   b = 8'h33;
            4'd11:   b = 8'h33;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // i2c_ready comes from the master's clock domain. A two-flop synchroniser
    // brings it into this domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_meta <= 1'b0;
            rdy        <= 1'b0;
        end else begin
            ready_meta <= i2c_ready;
            rdy        <= ready_meta;
        end
    end

    // This is the main sequencer FSM. All outputs are registered here.
    // go is only looked at in IDLE, DONE and ERROR. busy is low in those
    // states, so a go pulse during a sequence is dropped.
    // A timeout abort goes straight to ERROR and cannot coincide with an
    // accepted go, so the timeout always wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            i2c_start <= 1'b0;
            i2c_data  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            step      <= 4'd0;
            tmr       <= 16'd0;
            gap_cnt   <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (go) begin
                        state <= S_LOAD;
                        step  <= 4'd0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end

                S_LOAD: begin
                    i2c_data <= table_byte(step);
                    tmr      <= 16'd0;
                    state    <= S_ISSUE;
                end

                // Wait for the master to be idle before requesting. This
                // guarantees i2c_start never rises while rdy=0.
                S_ISSUE: begin
                    if (tmr == TIMEOUT) begin
                        state     <= S_ERROR;
                        i2c_start <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        tmr       <= 16'd0;
                    end else if (rdy) begin
                        i2c_start <= 1'b1;
                        tmr       <= 16'd0;
                        state     <= S_ACCEPT;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end

                // Hold the request until the master drops rdy to show it has
                // taken the byte.
                S_ACCEPT: begin
                    if (tmr == TIMEOUT) begin
                        state     <= S_ERROR;
                        i2c_start <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        tmr       <= 16'd0;
                    end else if (!rdy) begin
                        i2c_start <= 1'b0;
                        tmr       <= 16'd0;
                        state     <= S_COMPLETE;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end

                // rdy returning high means the bus write has finished.
                S_COMPLETE: begin
                    if (tmr == TIMEOUT) begin
                        state     <= S_ERROR;
                        i2c_start <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        tmr       <= 16'd0;
                    end else if (rdy) begin
                        gap_cnt <= 16'd0;
                        tmr     <= 16'd0;
                        state   <= S_GAP;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end

                // The camera needs this settle time after every write,
                // including the last one.
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (step == LAST_STEP) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            step  <= step + 4'd1;
                            state <= S_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    i2c_start <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
